// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the audio capture and playback blocks.
//   AUDIO_ADDR_W      - sample RAM address width (also the capture default)
//   AUDIO_DATA_W      - sample width in bits
//   AUDIO_NUM_SAMPLES - samples per captured buffer
//   play_state_t      - playback FSM state encoding
package audio_pkg;

  localparam int AUDIO_ADDR_W      = 11;
  localparam int AUDIO_DATA_W      = 10;
  localparam int AUDIO_NUM_SAMPLES = 2048;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAYING,
    DONE
  } play_state_t;

endpackage

// File: rtl/play_audio_if.sv
// play_audio_if: bundles the playback block's control, RAM read and amplifier signals.
//   do_play_audio  - start pulse from the sequencer
//   did_play_audio - one-cycle completion pulse
//   read_enable    - RAM read strobe
//   mem_addr       - RAM read address
//   data_in        - RAM read data
//   audPwm         - PWM audio output
//   audSd          - amplifier enable
// Modports: master = playback block, slave = sequencer/RAM/board side.
//
// Handshake semantics: do_play_audio is a single-cycle request that is only
// honoured while the block is idle (there is no ready, extra pulses are
// dropped); did_play_audio is a single-cycle response with no back-pressure.
// The RAM read has fixed latency: data_in must be valid on the cycle after
// read_enable is high, and is not sampled at any other time.
interface play_audio_if
  import audio_pkg::*;
#(
  parameter int ADDR_W = AUDIO_ADDR_W,
  parameter int DATA_W = AUDIO_DATA_W
);

  logic              do_play_audio;
  logic              did_play_audio;
  logic              read_enable;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_in;
  logic              audPwm;
  logic              audSd;

  modport master (
    input  do_play_audio,
    input  data_in,
    output did_play_audio,
    output read_enable,
    output mem_addr,
    output audPwm,
    output audSd
  );

  modport slave (
    output do_play_audio,
    output data_in,
    input  did_play_audio,
    input  read_enable,
    input  mem_addr,
    input  audPwm,
    input  audSd
  );

endinterface

// File: rtl/play_audio_pwm_gen.sv
// pwm_gen: PWM carrier and per-sample repeat counting for audio playback.
//   clk, rst   - clock and synchronous active-high reset
//   clear      - zero both counters (sample being loaded)
//   en         - carrier running (sample being played)
//   duty       - number of high cycles per carrier period
//   pwm        - PWM output, decoded from counter registers only
//   period_end - high on the last cycle of the last carrier period of a sample
module pwm_gen #(
  parameter int DATA_W         = 10,
  parameter int SAMPLE_PERIODS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] duty,
  output logic              pwm,
  output logic              period_end
);

  localparam int                REP_W    = $clog2(SAMPLE_PERIODS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(SAMPLE_PERIODS - 1);

  logic [DATA_W-1:0] pwm_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic              wrap;

  // The carrier wraps naturally at 2^DATA_W-1, so the all-ones value marks
  // the final cycle of each carrier period.
  assign wrap = &pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pwm_cnt <= '0;
      rep_cnt <= '0;
    end else if (en) begin
      pwm_cnt <= pwm_cnt + DATA_W'(1);
      if (wrap) begin
        rep_cnt <= rep_cnt + REP_W'(1);
      end
    end
  end

  assign pwm        = en && (pwm_cnt < duty);
  assign period_end = en && wrap && (rep_cnt == REP_LAST);

endmodule

// File: rtl/play_audio.sv
// play_audio: plays NUM_SAMPLES samples from the sample RAM out as PWM.
// A start pulse in IDLE reads each sample once (FETCH, then LOAD one cycle
// later when RAM data is valid), plays it for SAMPLE_PERIODS carrier periods
// of 2^DATA_W clocks, and pulses did_play_audio after the last sample.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset; aborts a run silently
//   bus       - play_audio_if master modport (start/done, RAM read, PWM, amp enable)
//   dbg_state - current FSM state
// Optional build macro: PLAY_AUDIO_SIGNED_EN treats samples as two's
// complement and converts them to offset-binary duty values.
module play_audio
  import audio_pkg::*;
#(
  parameter int ADDR_W         = AUDIO_ADDR_W,
  parameter int DATA_W         = AUDIO_DATA_W,
  parameter int NUM_SAMPLES    = AUDIO_NUM_SAMPLES,
  parameter int SAMPLE_PERIODS = 3
) (
  input  logic               clk,
  input  logic               rst,
  play_audio_if.master       bus,
  output play_state_t        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

  play_state_t       state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] sample_reg;
  logic [DATA_W-1:0] duty;
  logic              read_enable_q;
  logic              did_q;
  logic              sd_q;
  logic              period_end;
  logic              pwm;

`ifdef PLAY_AUDIO_SIGNED_EN
  // Flipping the sign bit maps two's complement onto offset binary:
  // most negative -> 0, zero -> mid-scale, most positive -> full scale.
  assign duty = {~sample_reg[DATA_W-1], sample_reg[DATA_W-2:0]};
`else
  assign duty = sample_reg;
`endif

  // Outputs are registered: each transition sets the values that belong to
  // the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      sample_reg    <= '0;
      read_enable_q <= 1'b0;
      did_q         <= 1'b0;
      sd_q          <= 1'b0;
    end else begin
      read_enable_q <= 1'b0;
      did_q         <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.do_play_audio) begin
            idx           <= '0;
            state         <= FETCH;
            read_enable_q <= 1'b1;
            sd_q          <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          sample_reg <= bus.data_in;
          state      <= PLAYING;
        end
        PLAYING: begin
          if (period_end) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
              did_q <= 1'b1;
            end else begin
              idx           <= idx + ADDR_W'(1);
              state         <= FETCH;
              read_enable_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // Return idx to 0 so mem_addr reads 0 while idle.
          idx   <= '0;
          sd_q  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          idx   <= '0;
          sd_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  pwm_gen #(
    .DATA_W         (DATA_W),
    .SAMPLE_PERIODS (SAMPLE_PERIODS)
  ) u_pwm_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == LOAD),
    .en         (state == PLAYING),
    .duty       (duty),
    .pwm        (pwm),
    .period_end (period_end)
  );

  assign bus.read_enable    = read_enable_q;
  assign bus.mem_addr       = idx;
  assign bus.did_play_audio = did_q;
  assign bus.audSd          = sd_q;
  assign bus.audPwm         = pwm;
  assign dbg_state          = state;

endmodule

// File: tb/tb_play_audio.sv
// tb_play_audio: three playback instances (4 samples x 1 period, 1 sample x
// 3 periods, 3 samples x 1 period) driven from a sample table; read, PWM
// window and done events are predicted into a queue and compared as they occur.
module tb_play_audio;
  import audio_pkg::*;

  localparam int AW = 11;
  localparam int DW = 10;
  localparam int EV_READ = 0;
  localparam int EV_HIGH = 1;
  localparam int EV_DONE = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  play_audio_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  play_audio_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();
  play_audio_if #(.ADDR_W(AW), .DATA_W(DW)) bus_c ();

  play_state_t dbg [3];
  logic        start [3];
  logic [DW-1:0] ram [3][4];

  play_audio #(.ADDR_W(AW), .DATA_W(DW), .NUM_SAMPLES(4), .SAMPLE_PERIODS(1))
    u_a (.clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg[0]));
  play_audio #(.ADDR_W(AW), .DATA_W(DW), .NUM_SAMPLES(1), .SAMPLE_PERIODS(3))
    u_b (.clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg[1]));
  play_audio #(.ADDR_W(AW), .DATA_W(DW), .NUM_SAMPLES(3), .SAMPLE_PERIODS(1))
    u_c (.clk(clk), .rst(rst), .bus(bus_c), .dbg_state(dbg[2]));

  assign bus_a.do_play_audio = start[0];
  assign bus_b.do_play_audio = start[1];
  assign bus_c.do_play_audio = start[2];

  // RAM models: one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      bus_a.data_in <= '0;
      bus_b.data_in <= '0;
      bus_c.data_in <= '0;
    end else begin
      if (bus_a.read_enable) bus_a.data_in <= ram[0][bus_a.mem_addr[1:0]];
      if (bus_b.read_enable) bus_b.data_in <= ram[1][bus_b.mem_addr[1:0]];
      if (bus_c.read_enable) bus_c.data_in <= ram[2][bus_c.mem_addr[1:0]];
    end
  end

  logic          obs_re   [3];
  logic          obs_done [3];
  logic          obs_pwm  [3];
  logic          obs_sd   [3];
  logic [AW-1:0] obs_addr [3];
  assign obs_re[0] = bus_a.read_enable;  assign obs_done[0] = bus_a.did_play_audio;
  assign obs_pwm[0] = bus_a.audPwm;      assign obs_sd[0] = bus_a.audSd;
  assign obs_addr[0] = bus_a.mem_addr;
  assign obs_re[1] = bus_b.read_enable;  assign obs_done[1] = bus_b.did_play_audio;
  assign obs_pwm[1] = bus_b.audPwm;      assign obs_sd[1] = bus_b.audSd;
  assign obs_addr[1] = bus_b.mem_addr;
  assign obs_re[2] = bus_c.read_enable;  assign obs_done[2] = bus_c.did_play_audio;
  assign obs_pwm[2] = bus_c.audPwm;      assign obs_sd[2] = bus_c.audSd;
  assign obs_addr[2] = bus_c.mem_addr;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  int          n_chk;
  int          n_pass;
  int          exp_hi [3][4];

  typedef struct {
    int            dut;
    int            addr;
    logic [DW-1:0] sample;
    int            exp_high;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [31:0] ev(input int kind, input int cyc, input int val);
    return {kind[1:0], cyc[15:0], val[13:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, expv);
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: got unexpected event %08h, expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    return {20'd0, obs_re[d], obs_done[d], obs_pwm[d], obs_sd[d], 1'b0, obs_addr[d]};
  endfunction

  // ---------------- driver / monitor ----------------
  // Full run on DUT d: pushes the predicted event stream, pulses start, then
  // watches every cycle. ign1/ign2 are cycles with an extra (ignored) start.
  task automatic run(input int d, input int n, input int sp, input int ign1, input int ign2);
    int p, last, hi, gap_hi, sd_err, k, off;
    p    = sp * 1024 + 2;
    last = 1 + n * p;
    for (int s = 0; s < n; s++) begin
      exp_q.push_back(ev(EV_READ, 1 + s * p, s));
      for (int r = 0; r < sp; r++) exp_q.push_back(ev(EV_HIGH, s * sp + r, exp_hi[d][s]));
    end
    exp_q.push_back(ev(EV_DONE, last, 0));
    hi = 0; gap_hi = 0; sd_err = 0;
    @(negedge clk);
    start[d] = 1'b1;
    for (int c = 1; c <= last + 3; c++) begin
      @(negedge clk);
      start[d] = (c == ign1 || c == ign2);
      if (obs_re[d])   sb_check("read_event", ev(EV_READ, c, int'(obs_addr[d])));
      if (obs_done[d]) sb_check("done_event", ev(EV_DONE, c, 0));
      if (obs_sd[d] !== (c <= last)) sd_err++;
      k   = (c - 1) / p;
      off = (c - 1) % p;
      if (c <= n * p && off >= 2) begin
        if (obs_pwm[d]) hi++;
        if ((off - 2) % 1024 == 1023) begin
          sb_check("pwm_high_count", ev(EV_HIGH, k * sp + (off - 2) / 1024, hi));
          hi = 0;
        end
      end else if (obs_pwm[d]) begin
        gap_hi++;
      end
    end
    start[d] = 1'b0;
    chk("audSd_active_window", sd_err, 0);
    chk("pwm_outside_playing", gap_hi, 0);
    chk("idle_after_run", outs(d), 0);
    while (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL missing_event: got nothing, expected %08h", exp_q.pop_front());
    end
  endtask

  // Reset during sample 2 of DUT a: outputs clear at once, no done follows.
  task automatic reset_mid_run();
    int viol;
    @(negedge clk);
    start[0] = 1'b1;
    for (int c = 1; c <= 2 * 1026 + 500; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("pre_reset_playing", obs_sd[0], 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("outputs_in_reset", outs(0), 0);
    end
    rst = 1'b0;
    viol = 0;
    for (int c = 0; c < 3200; c++) begin
      @(negedge clk);
      if (outs(0) != 0) viol++;
    end
    chk("quiet_after_reset", viol, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      for (int a = 0; a < 4; a++) begin
        ram[d][a] = '0;
        exp_hi[d][a] = 0;
      end
    end

    vecs[0] = '{0, 0, 10'd0,    0};
    vecs[1] = '{0, 1, 10'd256,  256};
    vecs[2] = '{0, 2, 10'd512,  512};
    vecs[3] = '{0, 3, 10'd1023, 1023};
    vecs[4] = '{1, 0, 10'd100,  100};
`ifdef PLAY_AUDIO_SIGNED_EN
    vecs[5] = '{2, 0, 10'h200, 0};
    vecs[6] = '{2, 1, 10'h1FF, 1023};
    vecs[7] = '{2, 2, 10'h000, 512};
`else
    vecs[5] = '{2, 0, 10'h200, 512};
    vecs[6] = '{2, 1, 10'h1FF, 511};
    vecs[7] = '{2, 2, 10'h000, 0};
`endif
    for (int i = 0; i < 8; i++) begin
      ram[vecs[i].dut][vecs[i].addr]    = vecs[i].sample;
      exp_hi[vecs[i].dut][vecs[i].addr] = vecs[i].exp_high;
    end

    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_outputs", outs(d), 0);
      chk("reset_state", 32'(dbg[d]), 32'(IDLE));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, 4, 1, 0, 0);       // basic run
    run(0, 4, 1, 500, 1027);  // extra starts ignored
    run(1, 1, 3, 0, 0);       // repeat scaling
    run(2, 3, 1, 0, 0);       // sign handling
    reset_mid_run();
    run(0, 4, 1, 0, 0);       // restart after abort

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
